led_blink_scheduler: RTL and testbench



---
 rtl/led_sched_pkg.sv | 33 +++
 rtl/led_step_prescaler.sv | 34 +++
 rtl/led_blink_scheduler.sv | 108 ++++++++++
 tb/tb_led_blink_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared constants for the LED blink scheduler: mode encodings, LED count,
// step-index width and the pattern lookup used by the LED register.
package led_sched_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_CHASE = 2'd1;
   localparam logic [1:0] MODE_COUNT = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   localparam int NUM_LEDS = 4;
   localparam int STEP_W   = 4;

   typedef enum logic [1:0] {
      S_OFF   = MODE_OFF,
      S_CHASE = MODE_CHASE,
      S_COUNT = MODE_COUNT,
      S_BLINK = MODE_BLINK
   } mode_e;

   // Bit 0 is LED1, bit 3 is LED4.
   function automatic logic [NUM_LEDS-1:0] led_pattern(input mode_e m,
                                                       input logic [STEP_W-1:0] s);
      logic [NUM_LEDS-1:0] one;
      one = {{(NUM_LEDS-1){1'b0}}, 1'b1};
      case (m)
         S_CHASE: return one << s[1:0];
         S_COUNT: return s[NUM_LEDS-1:0];
         S_BLINK: return {NUM_LEDS{s[3]}};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Free-running prescaler: counts 0..CLKS_PER_STEP-1 and flags the last count
// as the step tick. i_Clr restarts the count so a new pattern begins at step 0.
module led_step_prescaler #(
   parameter int CLKS_PER_STEP = 1250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Clr,
   output logic o_Tick
);

   localparam int CNT_W = $clog2(CLKS_PER_STEP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_STEP - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign o_Tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (i_Clr || o_Tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_blink_scheduler.sv
// Maps a free-running step index onto four LEDs according to the current mode.
// Optional activity override (forces LEDs on) is built only with LED_ACTIVITY_EN.
module led_blink_scheduler
   import led_sched_pkg::*;
#(
   parameter int CLKS_PER_STEP  = 1250000,
   parameter int ACT_HOLD_STEPS = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Mode_Next,
   input  logic       i_Activity,
   output logic [1:0] o_Mode,
   output logic       o_LED_1,
   output logic       o_LED_2,
   output logic       o_LED_3,
   output logic       o_LED_4
);

   mode_e               mode_q, mode_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                tick;
   logic                force_on;

   led_step_prescaler #(
      .CLKS_PER_STEP (CLKS_PER_STEP)
   ) u_prescaler (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Clr   (i_Mode_Next),
      .o_Tick  (tick)
   );

   // Mode FSM: a mode change restarts the step index, and wins over a tick.
   always_comb begin
      mode_d = mode_q;
      step_d = step_q;
      if (i_Mode_Next) begin
         case (mode_q)
            S_OFF:   mode_d = S_CHASE;
            S_CHASE: mode_d = S_COUNT;
            S_COUNT: mode_d = S_BLINK;
            default: mode_d = S_OFF;
         endcase
         step_d = '0;
      end else if (tick) begin
         step_d = step_q + 1'b1;
      end
   end

`ifdef LED_ACTIVITY_EN
   localparam int OVR_W = $clog2(ACT_HOLD_STEPS + 1);
   localparam logic [OVR_W-1:0] OVR_LOAD = OVR_W'(ACT_HOLD_STEPS);

   logic [OVR_W-1:0] ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (i_Activity) begin
         ovr_d = OVR_LOAD;
      end else if (tick && (ovr_q != '0)) begin
         ovr_d = ovr_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         ovr_q <= '0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign force_on = (ovr_d != '0);
`else
   logic unused_act;
   assign unused_act = i_Activity | (ACT_HOLD_STEPS < 1);
   assign force_on   = 1'b0;
`endif

   // LEDs follow the next-state mode/step so changes land on the same edge.
   always_comb begin
      led_d = led_pattern(mode_d, step_d);
      if (force_on) begin
         led_d = '1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         mode_q <= S_OFF;
         step_q <= '0;
         led_q  <= '0;
      end else begin
         mode_q <= mode_d;
         step_q <= step_d;
         led_q  <= led_d;
      end
   end

   assign o_Mode  = mode_q;
   assign o_LED_1 = led_q[0];
   assign o_LED_2 = led_q[1];
   assign o_LED_3 = led_q[2];
   assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: directed scenarios plus random pulses, scored
// against a cycle-count based reference model of mode, step and override.
module tb_led_blink_scheduler;

   localparam int C = 4;
   localparam int H = 2;
   localparam int W = 6;

   logic       clk;
   logic       rst_n;
   logic       mode_next;
   logic       activity;
   logic [1:0] o_mode;
   logic       led1, led2, led3, led4;

   led_blink_scheduler #(
      .CLKS_PER_STEP  (C),
      .ACT_HOLD_STEPS (H)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_n),
      .i_Mode_Next (mode_next),
      .i_Activity  (activity),
      .o_Mode      (o_mode),
      .o_LED_1     (led1),
      .o_LED_2     (led2),
      .o_LED_3     (led3),
      .o_LED_4     (led4)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   // reference model: mode, clocks since last prescaler restart, step, override
   int m_mode = 0;
   int m_cyc  = 0;
   int m_step = 0;
   int m_ovr  = 0;

`ifdef LED_ACTIVITY_EN
   localparam bit ACT_EN = 1'b1;
`else
   localparam bit ACT_EN = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_leds();
      int p;
      if (m_ovr > 0) return 15;
      case (m_mode)
         1: p = 1 << (m_step % 4);
         2: p = m_step;
         3: p = (m_step >= 8) ? 15 : 0;
         default: p = 0;
      endcase
      return p;
   endfunction

   function automatic logic [W-1:0] observed();
      return {o_mode, led4, led3, led2, led1};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cyc = 0; m_step = 0; m_ovr = 0;
   endtask

   task automatic model_edge(input logic mn, input logic act);
      bit tick;
      tick = ((m_cyc % C) == C - 1);
      if (mn) begin
         m_mode = (m_mode + 1) % 4;
         m_cyc  = 0;
         m_step = 0;
      end else begin
         m_cyc = m_cyc + 1;
         if (tick) m_step = (m_step + 1) % 16;
      end
      if (ACT_EN && act) m_ovr = H;
      else if (tick && m_ovr > 0) m_ovr = m_ovr - 1;
      exp_q.push_back({2'(m_mode), 4'(model_leds())});
   endtask

   task automatic score(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_noexp"}, 6'd0, 6'd1);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, observed(), e);
      end
   endtask

   // driver: one clock with the given pulses, then score the result
   task automatic cyc(input logic mn, input logic act, input string tag);
      mode_next = mn;
      activity  = act;
      @(posedge clk);
      model_edge(mn, act);
      #1;
      mode_next = 1'b0;
      activity  = 1'b0;
      score(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      mode_next = 1'b0;
      activity  = 1'b0;
      model_reset();
      #1;
      check_val("reset_state", observed(), 6'd0);

      // 1: reset held 5 clocks, then idle in OFF
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("reset_hold", observed(), 6'd0);
      end
      rst_n = 1'b1;
      run(40, "t1_off");

      // 2: into CHASE, walk the one-hot pattern
      cyc(1'b1, 1'b0, "t2_enter");
      check_val("t2_mode_led1", observed(), {2'd1, 4'b0001});
      run(16, "t2_chase");
      check_val("t2_wrap_led1", observed(), {2'd1, 4'b0001});

      // 3: into COUNT, full binary sweep, then back to OFF
      cyc(1'b1, 1'b0, "t3_enter");
      check_val("t3_count0", observed(), {2'd2, 4'd0});
      run(66, "t3_count");
      cyc(1'b1, 1'b0, "t3_blink");
      cyc(1'b1, 1'b0, "t3_off");
      check_val("t3_off_leds", observed(), 6'd0);

      // 4: mode change coinciding with a tick at index 5 in COUNT
      cyc(1'b1, 1'b0, "t4_m1");
      cyc(1'b1, 1'b0, "t4_m2");
      begin
         int guard = 0;
         while (!(m_mode == 2 && m_step == 5 && (m_cyc % C) == C - 1) && guard < 200) begin
            cyc(1'b0, 1'b0, "t4_seek");
            guard++;
         end
         if (guard >= 200) check_val("t4_align_timeout", 6'd0, 6'd1);
      end
      check_val("t4_at5", observed(), {2'd2, 4'd5});
      cyc(1'b1, 1'b0, "t4_switch");
      check_val("t4_mode3_step0", observed(), {2'd3, 4'd0});
      run(12, "t4_after");

      // 5: activity override in CHASE, with a retrigger at one step left
      cyc(1'b1, 1'b0, "t5_m0");
      cyc(1'b1, 1'b0, "t5_m1");
      run(2, "t5_pre");
      cyc(1'b0, 1'b1, "t5_act");
      check_val("t5_forced", observed(), {2'd1, ACT_EN ? 4'b1111 : 4'b0001});
`ifdef LED_ACTIVITY_EN
      begin
         int guard = 0;
         while (m_ovr != 1 && guard < 20) begin
            cyc(1'b0, 1'b0, "t5_wait");
            guard++;
         end
         if (guard >= 20) check_val("t5_wait_timeout", 6'd0, 6'd1);
      end
`else
      run(3, "t5_wait");
`endif
      cyc(1'b0, 1'b1, "t5_retrig");
      run(14, "t5_hold");

      // 6: asynchronous reset in the middle of an override in COUNT
      cyc(1'b1, 1'b0, "t6_m2");
      run(3, "t6_pre");
      cyc(1'b0, 1'b1, "t6_act");
      run(1, "t6_mid");
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_async_rst", observed(), 6'd0);
      model_reset();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_val("t6_rst_hold", observed(), 6'd0);
      end
      rst_n = 1'b1;
      run(20, "t6_off");

      // random pulses across all modes
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
